// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier datapath: default operand width and
// the modular-exponentiation controller state encoding.
package paillier_pkg;

  localparam int unsigned W_DEFAULT = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    SQR_ISSUE = 3'd2,
    SQR_WAIT  = 3'd3,
    MUL_ISSUE = 3'd4,
    MUL_WAIT  = 3'd5,
    NEXT      = 3'd6,
    FIN       = 3'd7
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving an external
// modular multiplier over a ds/ready handshake.
module modexp_ctrl
  import paillier_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         mm_ds,
  output logic [W-1:0] mm_a,
  output logic [W-1:0] mm_b,
  output logic [W-1:0] mm_mod,
  input  logic         mm_ready,
  input  logic [W-1:0] mm_p
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t        state, state_nxt;
  logic [W-1:0]  b_q, e_q, n_q, r_q;
  logic [W-1:0]  b_nxt, e_nxt, n_nxt, r_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          busy_nxt, done_nxt, ds_nxt;
  logic [W-1:0]  a_nxt, bop_nxt, mod_nxt;

  // Next-state, datapath and multiplier-request decode
  always_comb begin
    state_nxt = state;
    b_nxt     = b_q;
    e_nxt     = e_q;
    n_nxt     = n_q;
    r_nxt     = r_q;
    cnt_nxt   = cnt_q;
    ds_nxt    = 1'b0;
    a_nxt     = mm_a;
    bop_nxt   = mm_b;
    mod_nxt   = mm_mod;

    case (state)
      IDLE: begin
        if (start) begin
          b_nxt     = base;
          e_nxt     = exp;
          n_nxt     = modulus;
          cnt_nxt   = CW'(W);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        e_nxt   = e_q << 1;
        cnt_nxt = cnt_q - CW'(1);
        if (e_q[W-1]) begin
          r_nxt     = b_q;
          state_nxt = NEXT;
        end else if (cnt_q == CW'(1)) begin
          // Exponent is zero: every bit scanned without finding a one
          r_nxt     = W'(1);
          state_nxt = FIN;
        end
      end
      NEXT: begin
        state_nxt = (cnt_q == '0) ? FIN : SQR_ISSUE;
      end
      SQR_ISSUE: begin
        if (!mm_ready) begin
          ds_nxt    = 1'b1;
          a_nxt     = r_q;
          bop_nxt   = r_q;
          mod_nxt   = n_q;
          state_nxt = SQR_WAIT;
        end
      end
      SQR_WAIT: begin
        if (mm_ready) begin
          r_nxt     = mm_p;
          e_nxt     = e_q << 1;
          cnt_nxt   = cnt_q - CW'(1);
          state_nxt = e_q[W-1] ? MUL_ISSUE : NEXT;
        end
      end
      MUL_ISSUE: begin
        if (!mm_ready) begin
          ds_nxt    = 1'b1;
          a_nxt     = b_q;
          bop_nxt   = r_q;
          mod_nxt   = n_q;
          state_nxt = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (mm_ready) begin
          r_nxt     = mm_p;
          state_nxt = NEXT;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

  // State, operand registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      b_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mm_ds  <= 1'b0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_mod <= '0;
    end else begin
      state  <= state_nxt;
      b_q    <= b_nxt;
      e_q    <= e_nxt;
      n_q    <= n_nxt;
      r_q    <= r_nxt;
      cnt_q  <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      if (done_nxt) begin
        result <= r_nxt;
      end
      mm_ds  <= ds_nxt;
      mm_a   <= a_nxt;
      mm_b   <= bop_nxt;
      mm_mod <= mod_nxt;
    end
  end

endmodule
